mvm_stream_param: RTL and testbench
===================================

// Module: mvm_stream_param
// PURPOSE
// Parametrised, streaming successor to the fixed k/p/b matrix-vector multiplier.
// Computes y = A*x for a KxK signed matrix A and a K-element signed vector x.
// Loads A and x through a valid/ready input stream and computes P output rows in parallel.
// Returns y through a valid/ready output stream with signed saturation to OUT_W bits.
// Sits between the host load interface and downstream consumers of y.
// PARAMETERS
// K       32  matrix/vector dimension; K >= 2; K % P == 0
// P       4   parallel MAC lanes (rows computed concurrently); 1 <= P <= K
// B       8   signed input element width
// OUT_W   16  signed output width; results saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
// ACC_W   2*B+$clog2(K)  internal accumulator width (derived localparam; never overflows)
// PORTS
// clk          in   1      clock, all logic rising-edge
// reset        in   1      synchronous, active-high
// load_matrix  in   1      command: load K*K elements of A, row-major
// load_vector  in   1      command: load K elements of x
// start        in   1      command: compute y = A*x and stream it out
// in_valid     in   1      input element valid
// in_ready     out  1      block accepts an element (high only in LOAD_A/LOAD_X)
// in_data      in   B      signed input element
// out_valid    out  1      y element valid
// out_ready    in   1      downstream accepts y element
// out_data     out  OUT_W  saturated signed y[i], i = 0..K-1 in order
// busy         out  1      high whenever state != IDLE
// done         out  1      one-cycle pulse after the last y beat handshakes
// BEHAVIOUR
// Reset: state=IDLE; in_ready, out_valid, busy and done are 0; out_data is 0.
//  A/x/y storage is not cleared.
// Reset wins over every other event. Reset mid-load or mid-compute aborts to IDLE
//  with no done pulse. A partially loaded A or x keeps whatever was written.
// FSM: IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
// IDLE:
//  - Commands are sampled only in IDLE, with priority start > load_matrix > load_vector.
//  - Commands seen in any other state are ignored.
// LOAD_A / LOAD_X:
//  - in_ready=1. Each in_valid&&in_ready beat writes one element at the next address.
//  - The address counter wraps to 0 after the last element and the FSM returns to IDLE.
//  - LOAD_A takes K*K beats; LOAD_X takes K beats.
//  - in_valid low stalls the load with no timeout.
// COMPUTE:
//  - Rows are processed in K/P groups; lane j of group g computes row g*P+j.
//  - Per group, columns 0..K-1 are streamed one per cycle.
//  - Pipeline per group: registered A/x read -> registered product -> accumulate.
//  - Each group therefore takes K+3 cycles, and group g's P results are written to y storage.
//  - Accumulators clear at group start; there is no bubble between groups beyond the 3 cycles.
//  - COMPUTE takes exactly (K/P)*(K+3) cycles, then the FSM enters OUTPUT.
// Arithmetic:
//  - The product is B x B signed, giving 2B bits.
//  - Products are sign-extended to ACC_W before accumulation.
//  - Saturation to OUT_W is applied on write to y storage.
// OUTPUT:
//  - out_valid asserts the cycle after entering OUTPUT, presenting y[0].
//  - On out_valid&&out_ready, the index advances. While out_ready=0, out_valid and
//    out_data must hold stable.
//  - After the y[K-1] handshake: out_valid=0, done=1 for one cycle, FSM returns to IDLE.
//  - Back-to-back throughput is one y element per cycle when out_ready=1.
// start without a prior load uses current storage contents and is not an error.
// TESTING
// 1. K=4,P=2: A=identity, x={1,-2,3,-4}, start, out_ready=1
//    -> y={1,-2,3,-4}, done pulse after 4th beat.
// 2. K=4,P=1: all A=127, all x=127, OUT_W=16 -> each y=64516.
//    Saturates to 32767; all A=-128, x=127 -> -32768.
// 3. Defaults: random A, x, out_ready toggled 50%
//    -> y matches reference model; out_data stable during stalls.
// 4. Load A with in_valid gaps of 0-5 cycles, start asserted during LOAD_A
//    -> start ignored, all K*K beats stored, IDLE after the last one.
// 5. Reset asserted 10 cycles into COMPUTE -> next cycle busy=0, out_valid=0, no done.
//    A fresh start then yields the correct y.
// 6. load_matrix and start asserted in the same IDLE cycle -> COMPUTE entered, in_ready stays 0.

Source files
------------

// File: rtl/mvm_stream_param.sv
// Streaming K x K signed matrix-vector multiplier: A and x arrive over a valid/ready load
// port, P rows are accumulated in parallel, and saturated y streams out over valid/ready.
module mvm_stream_param #(
   parameter int K     = 32,
   parameter int P     = 4,
   parameter int B     = 8,
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_matrix,
   input  logic                    load_vector,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [B-1:0]     in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data,
   output logic                    busy,
   output logic                    done
);
   localparam int ACC_W = 2*B + $clog2(K);
   localparam int G     = K / P;
   localparam int AW    = $clog2(K*K);
   localparam int XW    = $clog2(K);
   localparam int CW    = $clog2(K+3);
   localparam int GW    = (G > 1) ? $clog2(G) : 1;
   localparam int EW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [AW-1:0] A_LAST   = AW'(K*K-1);
   localparam logic [AW-1:0] X_LAST   = AW'(K-1);
   localparam logic [XW-1:0] IDX_LAST = XW'(K-1);
   localparam logic [CW-1:0] C_LAST   = CW'(K+2);
   localparam logic [GW-1:0] G_LAST   = GW'(G-1);
   localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;
   state_t state_r, state_s;

   logic signed [B-1:0]     a_mem_r [K*K];
   logic signed [B-1:0]     x_mem_r [K];
   logic [OUT_W-1:0]        y_mem_r [K];

   logic [AW-1:0]           ld_addr_r;
   logic [CW-1:0]           cyc_r;
   logic [GW-1:0]           grp_r;
   logic [XW-1:0]           out_idx_r;
   logic                    in_ready_r, busy_r, done_r, out_valid_r, v1_r, v2_r;
   logic [OUT_W-1:0]        out_data_r;

   logic [XW-1:0]           col_s;
   logic [AW-1:0]           rd_addr_s [P];
   logic [XW-1:0]           wr_row_s  [P];
   logic signed [B-1:0]     a_rd_r [P];
   logic signed [B-1:0]     x_rd_r;
   logic signed [2*B-1:0]   prod_r [P];
   logic signed [ACC_W-1:0] acc_r  [P];

   function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
      logic signed [EW-1:0] e;
      e = {{(EW-ACC_W){v[ACC_W-1]}}, v};
      if (e > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
      else if (e < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
      else                  sat = e[OUT_W-1:0];
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Next-state logic; commands are only looked at in IDLE
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start)            state_s = COMPUTE;
            else if (load_matrix) state_s = LOAD_A;
            else if (load_vector) state_s = LOAD_X;
            else                  state_s = IDLE;
         end
         LOAD_A:  if (in_valid && in_ready_r && ld_addr_r == A_LAST) state_s = IDLE;
                  else state_s = LOAD_A;
         LOAD_X:  if (in_valid && in_ready_r && ld_addr_r == X_LAST) state_s = IDLE;
                  else state_s = LOAD_X;
         COMPUTE: if (cyc_r == C_LAST && grp_r == G_LAST) state_s = OUTPUT;
                  else state_s = COMPUTE;
         OUTPUT:  if (out_valid_r && out_ready && out_idx_r == IDX_LAST) state_s = IDLE;
                  else state_s = OUTPUT;
         default: state_s = IDLE;
      endcase
   end

   // Read addresses for the current column and write rows of the current group
   always_comb begin
      col_s = cyc_r[XW-1:0];
      for (int j = 0; j < P; j++) begin
         rd_addr_s[j] = AW'((int'(grp_r)*P + j)*K + int'(col_s));
         wr_row_s[j]  = XW'(int'(grp_r)*P + j);
      end
   end

   // Control: handshake flags, load/compute/output counters
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         ld_addr_r   <= '0;
         cyc_r       <= '0;
         grp_r       <= '0;
         out_idx_r   <= '0;
         v1_r        <= 1'b0;
         v2_r        <= 1'b0;
      end else begin
         in_ready_r <= (state_s == LOAD_A) || (state_s == LOAD_X);
         busy_r     <= (state_s != IDLE);
         done_r     <= 1'b0;
         v1_r       <= (state_r == COMPUTE) && (cyc_r < CW'(K));
         v2_r       <= v1_r;
         case (state_r)
            LOAD_A: if (in_valid && in_ready_r)
                       ld_addr_r <= (ld_addr_r == A_LAST) ? '0 : ld_addr_r + AW'(1);
            LOAD_X: if (in_valid && in_ready_r)
                       ld_addr_r <= (ld_addr_r == X_LAST) ? '0 : ld_addr_r + AW'(1);
            COMPUTE: begin
               if (cyc_r == C_LAST) begin
                  cyc_r <= '0;
                  grp_r <= (grp_r == G_LAST) ? '0 : grp_r + GW'(1);
               end else begin
                  cyc_r <= cyc_r + CW'(1);
               end
            end
            OUTPUT: begin
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
                  out_data_r  <= y_mem_r[out_idx_r];
               end else if (out_ready) begin
                  if (out_idx_r == IDX_LAST) begin
                     out_valid_r <= 1'b0;
                     out_idx_r   <= '0;
                     done_r      <= 1'b1;
                  end else begin
                     out_idx_r  <= out_idx_r + XW'(1);
                     out_data_r <= y_mem_r[out_idx_r + XW'(1)];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Storage and MAC pipeline: operand read -> product -> accumulate -> saturating y write
   always_ff @(posedge clk) begin
      if (!reset && in_valid && in_ready_r) begin
         if (state_r == LOAD_A) a_mem_r[ld_addr_r] <= in_data;
         if (state_r == LOAD_X) x_mem_r[ld_addr_r[XW-1:0]] <= in_data;
      end
      x_rd_r <= x_mem_r[col_s];
      for (int j = 0; j < P; j++) begin
         a_rd_r[j] <= a_mem_r[rd_addr_s[j]];
         prod_r[j] <= a_rd_r[j] * x_rd_r;
         if (cyc_r == '0)
            acc_r[j] <= '0;
         else if (v2_r)
            acc_r[j] <= acc_r[j] + {{(ACC_W-2*B){prod_r[j][2*B-1]}}, prod_r[j]};
         if (!reset && state_r == COMPUTE && cyc_r == C_LAST)
            y_mem_r[wr_row_s[j]] <= sat(acc_r[j]);
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
endmodule

// File: tb/tb_mvm_stream_param.sv
// Randomized bench for mvm_stream_param: loads A and x, compares streamed y against a
// plain-arithmetic reference with saturation, and exercises stalls, aborts and command rules.
module tb_mvm_stream_param;
   localparam int K = 32, P = 4, B = 8, OUT_W = 16;
   localparam int LAT = (K/P)*(K+3) + 1;

   logic clk = 1'b0, reset = 1'b1;
   logic load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [B-1:0] in_data = '0;
   logic in_ready, out_valid, busy, done;
   logic [OUT_W-1:0] out_data;

   int checks = 0, errors = 0;
   int a_m [K*K];
   int x_m [K];
   int exp_y [K];

   always #5 clk = ~clk;

   mvm_stream_param #(.K(K), .P(P), .B(B), .OUT_W(OUT_W)) dut (
      .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
      .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done));

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd_elem();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   function automatic void compute_ref();
      longint s;
      for (int i = 0; i < K; i++) begin
         s = 0;
         for (int c = 0; c < K; c++) s += longint'(a_m[i*K+c]) * longint'(x_m[c]);
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         exp_y[i] = int'(s);
      end
   endfunction

   task automatic load(input bit mat, input int gap_max, input bit poke_start);
      int n;
      bit ready_ok;
      n = mat ? K*K : K;
      ready_ok = 1'b1;
      load_matrix = mat;
      load_vector = !mat;
      tick;
      load_matrix = 1'b0;
      load_vector = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL load_enter: in_ready=%b busy=%b required 1 1", in_ready, busy);
      end
      for (int e = 0; e < n; e++) begin
         repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
         end
         start = 1'b0;
         in_valid = 1'b1;
         in_data = mat ? B'(a_m[e]) : B'(x_m[e]);
         if (in_ready !== 1'b1) ready_ok = 1'b0;
         tick;
      end
      in_valid = 1'b0;
      checks++;
      if (!ready_ok) begin
         errors++;
         $display("FAIL load_ready: in_ready dropped during load, required 1");
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_exit: busy=%b in_ready=%b required 0 0", busy, in_ready);
      end
   endtask

   task automatic run(input int ready_pct, input bit with_load_cmd);
      int cnt, idx;
      bit prev_stall, stable_ok, ready_low_ok, done_early;
      logic [OUT_W-1:0] prev_data, exp16;
      compute_ref();
      stable_ok = 1'b1; ready_low_ok = 1'b1; done_early = 1'b0; prev_stall = 1'b0;
      prev_data = '0;
      start = 1'b1;
      load_matrix = with_load_cmd;
      tick;
      start = 1'b0;
      load_matrix = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL cmd_start: busy=%b in_ready=%b required 1 0", busy, in_ready);
      end
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 2000) begin
         if (in_ready !== 1'b0) ready_low_ok = 1'b0;
         if (done !== 1'b0) done_early = 1'b1;
         tick;
         cnt++;
      end
      checks++;
      if (cnt != LAT) begin
         errors++;
         $display("FAIL latency: first out_valid after %0d cycles, required %0d", cnt, LAT);
      end
      idx = 0;
      cnt = 0;
      while (idx < K && cnt < 5000) begin
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stable_ok = 1'b0;
         if (done !== 1'b0) done_early = 1'b1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
         if (out_valid === 1'b1 && out_ready) begin
            exp16 = OUT_W'(exp_y[idx]);
            checks++;
            if (out_data !== exp16) begin
               errors++;
               $display("FAIL y[%0d]: got %0d required %0d", idx, $signed(out_data), $signed(exp16));
            end
            idx++;
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data = out_data;
         tick;
         cnt++;
      end
      out_ready = 1'b0;
      checks++;
      if (idx != K) begin
         errors++;
         $display("FAIL beats: got %0d y beats, required %0d", idx, K);
      end
      if (ready_pct == 100) begin
         checks++;
         if (cnt != K) begin
            errors++;
            $display("FAIL throughput: %0d cycles for %0d beats, required %0d", cnt, K, K);
         end
      end
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b out_valid=%b busy=%b required 1 0 0", done, out_valid, busy);
      end
      tick;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_clear: done=%b required 0", done);
      end
      checks++;
      if (!stable_ok || !ready_low_ok || done_early) begin
         errors++;
         $display("FAIL run_flags: stable=%b in_ready_low=%b early_done=%b required 1 1 0",
                  stable_ok, ready_low_ok, done_early);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) tick;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b done=%b out_data=%0d required all 0",
                  in_ready, out_valid, busy, done, out_data);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_identity;
      for (int i = 0; i < K*K; i++) a_m[i] = ((i / K) == (i % K)) ? 1 : 0;
      for (int i = 0; i < K; i++) x_m[i] = rnd_elem();
      load(1'b1, 0, 1'b0);
      load(1'b0, 0, 1'b0);
      run(100, 1'b0);
   endtask

   task automatic test_saturation;
      for (int i = 0; i < K*K; i++) a_m[i] = 127;
      for (int i = 0; i < K; i++) x_m[i] = 127;
      load(1'b1, 0, 1'b0);
      load(1'b0, 0, 1'b0);
      run(100, 1'b0);
      for (int i = 0; i < K*K; i++) a_m[i] = -128;
      load(1'b1, 0, 1'b0);
      run(60, 1'b0);
   endtask

   task automatic test_random_gaps;
      for (int i = 0; i < K*K; i++) a_m[i] = rnd_elem();
      for (int i = 0; i < K; i++) x_m[i] = rnd_elem();
      load(1'b1, 5, 1'b1);
      load(1'b0, 2, 1'b0);
      run(50, 1'b0);
   endtask

   task automatic test_reset_mid_compute;
      bit quiet;
      quiet = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (9) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: busy=%b out_valid=%b in_ready=%b required 0 0 0", busy, out_valid, in_ready);
      end
      repeat (300) begin
         if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
         tick;
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL abort_quiet: activity after reset abort, required none");
      end
      run(70, 1'b0);
   endtask

   task automatic test_cmd_priority;
      for (int i = 0; i < K; i++) x_m[i] = rnd_elem();
      load(1'b0, 1, 1'b0);
      run(100, 1'b1);
   endtask

   initial begin
      test_reset;
      test_identity;
      test_saturation;
      test_random_gaps;
      test_reset_mid_compute;
      test_cmd_priority;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
